// File: rtl/thor2025_regfile_wrarb_if.sv
// Writeback request bus: NREQ requesters share one register-file write port.
// The master side is the requesters and the slave side is the arbiter.
interface thor2025_regfile_wrarb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned WID  = 64,
  parameter int unsigned AW   = 7
);
  localparam int unsigned WB = WID / 8;

  logic [NREQ-1:0]      req;
  logic [NREQ*WB-1:0]   wea;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*WID-1:0]  dat;
  logic [NREQ-1:0]      gnt;

  modport master (
    output req,
    output wea,
    output addr,
    output dat,
    input  gnt
  );

  modport slave (
    input  req,
    input  wea,
    input  addr,
    input  dat,
    output gnt
  );
endinterface

// File: rtl/thor2025_regfile_wrarb.sv
// Register-file write-port controller: clears the RAM after reset or on request, then
// round-robin arbitrates writeback requesters onto the single registered write port.
module thor2025_regfile_wrarb #(
  parameter int unsigned WID  = 64,
  parameter int unsigned DEP  = 96,
  parameter int unsigned NREQ = 4,
  localparam int unsigned AW  = $clog2(DEP),
  localparam int unsigned WB  = WID / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  thor2025_regfile_wrarb_if.slave req_if,
  output logic                    ram_ena_o,
  output logic [WB-1:0]           ram_wea_o,
  output logic [AW-1:0]           ram_addra_o,
  output logic [WID-1:0]          ram_dina_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            ena_q, ena_d;
  logic [WB-1:0]   wea_q, wea_d;
  logic [AW-1:0]   addra_q, addra_d;
  logic [WID-1:0]  dina_q, dina_d;
  logic            err_q, err_d;

  logic            gnt_vld;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] gnt;
  logic [WB-1:0]   win_wea;
  logic [AW-1:0]   win_addr;
  logic [WID-1:0]  win_dat;
  logic            win_oor;
  int unsigned     idx;

  // Round-robin scan starting at the pointer; clr_i suppresses any grant that cycle.
  always_comb begin
    gnt_vld = 1'b0;
    win     = '0;
    idx     = 0;
    if (state_q == StRun && !clr_i) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        idx = 32'(ptr_q) + off;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_vld && req_if.req[idx]) begin
          gnt_vld = 1'b1;
          win     = PW'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[win] = 1'b1;
  end

  assign req_if.gnt = gnt;
  assign busy_o     = (state_q == StClear);

  assign win_wea  = req_if.wea[32'(win)*WB +: WB];
  assign win_addr = req_if.addr[32'(win)*AW +: AW];
  assign win_dat  = req_if.dat[32'(win)*WID +: WID];
  assign win_oor  = ({1'b0, win_addr} >= (AW+1)'(DEP));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    ena_d   = 1'b0;
    wea_d   = '0;
    addra_d = addra_q;
    dina_d  = dina_q;
    err_d   = 1'b0;

    unique case (state_q)
      StClear: begin
        ena_d   = 1'b1;
        wea_d   = '1;
        addra_d = cnt_q;
        dina_d  = '0;
        if (clr_i) begin
          cnt_d = '0;
        end else if (cnt_q == AW'(DEP - 1)) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (clr_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (gnt_vld) begin
          ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          // Out-of-range writes take their turn but never reach the RAM.
          if (win_oor) begin
            err_d = 1'b1;
          end else begin
            ena_d   = 1'b1;
            wea_d   = win_wea;
            addra_d = win_addr;
            dina_d  = win_dat;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
      ptr_q   <= '0;
      ena_q   <= 1'b0;
      wea_q   <= '0;
      addra_q <= '0;
      dina_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      err_q   <= err_d;
    end
  end

  assign ram_ena_o   = ena_q;
  assign ram_wea_o   = wea_q;
  assign ram_addra_o = addra_q;
  assign ram_dina_o  = dina_q;
  assign err_o       = err_q;

endmodule
